// File: rtl/basic_computer_pkg.sv
// Shared encodings for the Basic Computer control path: bus sources, ALU functions,
// register-reference bit positions and counter widths.
package basic_computer_pkg;

  localparam int unsigned ScWidth     = 4;
  localparam int unsigned OpcodeWidth = 3;
  localparam int unsigned DecodeWidth = 8;
  localparam int unsigned BusSelWidth = 3;
  localparam int unsigned AluOpWidth  = 3;

  localparam logic [ScWidth-1:0] ScMax = 4'hf;

  localparam logic [BusSelWidth-1:0] BusNone = 3'd0;
  localparam logic [BusSelWidth-1:0] BusAr   = 3'd1;
  localparam logic [BusSelWidth-1:0] BusPc   = 3'd2;
  localparam logic [BusSelWidth-1:0] BusDr   = 3'd3;
  localparam logic [BusSelWidth-1:0] BusAc   = 3'd4;
  localparam logic [BusSelWidth-1:0] BusIr   = 3'd5;
  localparam logic [BusSelWidth-1:0] BusTr   = 3'd6;
  localparam logic [BusSelWidth-1:0] BusMem  = 3'd7;

  localparam logic [AluOpWidth-1:0] AluAnd    = 3'd0;
  localparam logic [AluOpWidth-1:0] AluAdd    = 3'd1;
  localparam logic [AluOpWidth-1:0] AluPassDr = 3'd2;
  localparam logic [AluOpWidth-1:0] AluCma    = 3'd3;
  localparam logic [AluOpWidth-1:0] AluShr    = 3'd4;
  localparam logic [AluOpWidth-1:0] AluShl    = 3'd5;

  localparam int unsigned RrCla = 11;
  localparam int unsigned RrCle = 10;
  localparam int unsigned RrCma = 9;
  localparam int unsigned RrCme = 8;
  localparam int unsigned RrCir = 7;
  localparam int unsigned RrCil = 6;
  localparam int unsigned RrInc = 5;
  localparam int unsigned RrSpa = 4;
  localparam int unsigned RrSna = 3;
  localparam int unsigned RrSza = 2;
  localparam int unsigned RrSze = 1;
  localparam int unsigned RrHlt = 0;

  function automatic logic [DecodeWidth-1:0] decode_op(input logic [OpcodeWidth-1:0] op);
    logic [DecodeWidth-1:0] d;
    d     = '0;
    d[op] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/sequence_counter.sv
// Timing-step counter: counts while enabled, synchronous clear wins over increment.
module sequence_counter
  import basic_computer_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               clr,
  output logic [ScWidth-1:0] count
);

  logic [ScWidth-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = clr ? '0 : count_q + ScWidth'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/basic_control_unit.sv
// Hardwired timing-and-control unit of the Basic Computer: holds SC, D0-D7, I and S and
// decodes them into register strobes, bus select, memory strobes and ALU function.
module basic_control_unit
  import basic_computer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [15:0]            ir,
  input  logic                   e_q,
  input  logic                   ac_msb,
  input  logic                   ac_zero,
  input  logic                   dr_zero,
  output logic                   ar_load,
  output logic                   ar_inc,
  output logic                   ar_clr,
  output logic                   pc_load,
  output logic                   pc_inc,
  output logic                   pc_clr,
  output logic                   dr_load,
  output logic                   dr_inc,
  output logic                   ac_load,
  output logic                   ac_inc,
  output logic                   ac_clr,
  output logic                   ir_load,
  output logic                   e_clr,
  output logic                   e_load,
  output logic                   e_inc,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [BusSelWidth-1:0] bus_sel,
  output logic [AluOpWidth-1:0]  alu_op,
  output logic [ScWidth-1:0]     sc,
  output logic                   running
);

  logic [DecodeWidth-1:0] d_q;
  logic                   i_flag_q;
  logic                   s_flag_q;
  logic [ScWidth-1:0]     sc_q;
  logic                   active;
  logic                   step_clr;
  logic                   sc_clr;
  logic                   halt;

  // Strobes are gated by reset_n so nothing fires while reset is held.
  assign active = reset_n & s_flag_q;
  assign sc_clr = step_clr | (sc_q == ScMax);

  sequence_counter u_sequence_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (s_flag_q),
    .clr    (sc_clr),
    .count  (sc_q)
  );

  always_comb begin
    ar_load   = 1'b0;
    ar_inc    = 1'b0;
    ar_clr    = 1'b0;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_clr    = 1'b0;
    dr_load   = 1'b0;
    dr_inc    = 1'b0;
    ac_load   = 1'b0;
    ac_inc    = 1'b0;
    ac_clr    = 1'b0;
    ir_load   = 1'b0;
    e_clr     = 1'b0;
    e_load    = 1'b0;
    e_inc     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_sel   = BusNone;
    alu_op    = AluAnd;
    step_clr  = 1'b0;
    halt      = 1'b0;
    if (active) begin
      case (sc_q)
        4'd0: begin
          bus_sel = BusPc;
          ar_load = 1'b1;
        end
        4'd1: begin
          bus_sel  = BusMem;
          mem_read = 1'b1;
          ir_load  = 1'b1;
          pc_inc   = 1'b1;
        end
        4'd2: begin
          bus_sel = BusIr;
          ar_load = 1'b1;
        end
        4'd3: begin
          if (!d_q[7]) begin
            if (i_flag_q) begin
              bus_sel  = BusMem;
              mem_read = 1'b1;
              ar_load  = 1'b1;
            end
          end else begin
            step_clr = 1'b1;
            // Register reference: every selected micro-op fires in this one cycle.
            if (!i_flag_q) begin
              if (ir[RrCla]) ac_clr = 1'b1;
              if (ir[RrCle]) e_clr = 1'b1;
              if (ir[RrCma]) begin
                alu_op  = AluCma;
                ac_load = 1'b1;
              end
              if (ir[RrCme]) e_inc = 1'b1;
              if (ir[RrCir]) begin
                alu_op  = AluShr;
                ac_load = 1'b1;
                e_load  = 1'b1;
              end
              if (ir[RrCil]) begin
                alu_op  = AluShl;
                ac_load = 1'b1;
                e_load  = 1'b1;
              end
              if (ir[RrInc]) ac_inc = 1'b1;
              pc_inc = (ir[RrSpa] & ~ac_msb) | (ir[RrSna] & ac_msb) |
                       (ir[RrSza] & ac_zero) | (ir[RrSze] & ~e_q);
              halt   = ir[RrHlt];
            end
          end
        end
        4'd4: begin
          if (d_q[0] | d_q[1] | d_q[2] | d_q[6]) begin
            bus_sel  = BusMem;
            mem_read = 1'b1;
            dr_load  = 1'b1;
          end
          if (d_q[3]) begin
            bus_sel   = BusAc;
            mem_write = 1'b1;
            step_clr  = 1'b1;
          end
          if (d_q[4]) begin
            bus_sel  = BusAr;
            pc_load  = 1'b1;
            step_clr = 1'b1;
          end
          if (d_q[5]) begin
            bus_sel   = BusPc;
            mem_write = 1'b1;
            ar_inc    = 1'b1;
          end
        end
        4'd5: begin
          if (d_q[0]) begin
            alu_op   = AluAnd;
            ac_load  = 1'b1;
            step_clr = 1'b1;
          end
          if (d_q[1]) begin
            alu_op   = AluAdd;
            ac_load  = 1'b1;
            e_load   = 1'b1;
            step_clr = 1'b1;
          end
          if (d_q[2]) begin
            alu_op   = AluPassDr;
            ac_load  = 1'b1;
            step_clr = 1'b1;
          end
          if (d_q[5]) begin
            bus_sel  = BusAr;
            pc_load  = 1'b1;
            step_clr = 1'b1;
          end
          if (d_q[6]) dr_inc = 1'b1;
        end
        4'd6: begin
          if (d_q[6]) begin
            bus_sel   = BusDr;
            mem_write = 1'b1;
            pc_inc    = dr_zero;
            step_clr  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q      <= '0;
      i_flag_q <= 1'b0;
      s_flag_q <= 1'b1;
    end else begin
      if (s_flag_q && sc_q == 4'd2) begin
        d_q      <= decode_op(ir[14:12]);
        i_flag_q <= ir[15];
      end
      if (halt) s_flag_q <= 1'b0;
    end
  end

  assign sc      = sc_q;
  assign running = s_flag_q;

  // No legal instruction reaches T15; the counter is forced back to T0 if one does.
  illegal_sc: assert property (@(posedge clk) disable iff (!reset_n) s_flag_q |-> sc_q != ScMax);

endmodule

// File: tb/tb_basic_control_unit.sv
// Self-checking bench for basic_control_unit: per-cycle strobe comparison against an
// instruction-level reference table, directed cases plus randomized instruction streams.
module tb_basic_control_unit;
  import basic_computer_pkg::*;

  typedef struct packed {
    logic ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr, dr_load, dr_inc;
    logic ac_load, ac_inc, ac_clr, ir_load, e_clr, e_load, e_inc, mem_read, mem_write;
    logic [2:0] bus_sel;
    logic [2:0] alu_op;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ir = '0;
  logic        e_q = 1'b0, ac_msb = 1'b0, ac_zero = 1'b0, dr_zero = 1'b0;
  logic ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr, dr_load, dr_inc;
  logic ac_load, ac_inc, ac_clr, ir_load, e_clr, e_load, e_inc, mem_read, mem_write;
  logic [2:0] bus_sel, alu_op;
  logic [3:0] sc;
  logic       running;

  int n_checks = 0;
  int n_fail   = 0;
  obs_t exp_q [0:7];
  obs_t obs;

  always #5 clk = ~clk;

  assign obs = {ar_load, ar_inc, ar_clr, pc_load, pc_inc, pc_clr, dr_load, dr_inc,
                ac_load, ac_inc, ac_clr, ir_load, e_clr, e_load, e_inc, mem_read, mem_write,
                bus_sel, alu_op};

  basic_control_unit dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .e_q(e_q), .ac_msb(ac_msb), .ac_zero(ac_zero),
    .dr_zero(dr_zero), .ar_load(ar_load), .ar_inc(ar_inc), .ar_clr(ar_clr),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_clr(pc_clr), .dr_load(dr_load),
    .dr_inc(dr_inc), .ac_load(ac_load), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .ir_load(ir_load), .e_clr(e_clr), .e_load(e_load), .e_inc(e_inc),
    .mem_read(mem_read), .mem_write(mem_write), .bus_sel(bus_sel), .alu_op(alu_op),
    .sc(sc), .running(running)
  );

  // alu_op only matters when AC or E is loading.
  function automatic obs_t mask_alu(input obs_t o);
    obs_t m;
    m = o;
    if (!(m.ac_load || m.e_load)) m.alu_op = '0;
    return m;
  endfunction

  // Instruction-level reference: list of micro-operations per timing step.
  task automatic build_expect(input logic [15:0] iv, output int len);
    logic [2:0] op;
    logic       ind;
    for (int k = 0; k < 8; k++) exp_q[k] = '0;
    op  = iv[14:12];
    ind = iv[15];
    exp_q[0].bus_sel = 3'd2; exp_q[0].ar_load = 1'b1;
    exp_q[1].bus_sel = 3'd7; exp_q[1].mem_read = 1'b1;
    exp_q[1].ir_load = 1'b1; exp_q[1].pc_inc = 1'b1;
    exp_q[2].bus_sel = 3'd5; exp_q[2].ar_load = 1'b1;
    if (op == 3'd7) begin
      len = 4;
      if (!ind) begin
        if (iv[11]) exp_q[3].ac_clr = 1'b1;
        if (iv[10]) exp_q[3].e_clr = 1'b1;
        if (iv[9]) begin exp_q[3].ac_load = 1'b1; exp_q[3].alu_op = AluCma; end
        if (iv[8]) exp_q[3].e_inc = 1'b1;
        if (iv[7]) begin
          exp_q[3].ac_load = 1'b1; exp_q[3].e_load = 1'b1; exp_q[3].alu_op = AluShr;
        end
        if (iv[6]) begin
          exp_q[3].ac_load = 1'b1; exp_q[3].e_load = 1'b1; exp_q[3].alu_op = AluShl;
        end
        if (iv[5]) exp_q[3].ac_inc = 1'b1;
        if ((iv[4] && !ac_msb) || (iv[3] && ac_msb) || (iv[2] && ac_zero) || (iv[1] && !e_q))
          exp_q[3].pc_inc = 1'b1;
      end
    end else begin
      if (ind) begin
        exp_q[3].bus_sel = 3'd7; exp_q[3].mem_read = 1'b1; exp_q[3].ar_load = 1'b1;
      end
      case (op)
        3'd0, 3'd1, 3'd2: begin
          len = 6;
          exp_q[4].bus_sel = 3'd7; exp_q[4].mem_read = 1'b1; exp_q[4].dr_load = 1'b1;
          exp_q[5].ac_load = 1'b1;
          exp_q[5].alu_op  = (op == 3'd0) ? AluAnd : (op == 3'd1) ? AluAdd : AluPassDr;
          exp_q[5].e_load  = (op == 3'd1);
        end
        3'd3: begin
          len = 5;
          exp_q[4].bus_sel = 3'd4; exp_q[4].mem_write = 1'b1;
        end
        3'd4: begin
          len = 5;
          exp_q[4].bus_sel = 3'd1; exp_q[4].pc_load = 1'b1;
        end
        3'd5: begin
          len = 6;
          exp_q[4].bus_sel = 3'd2; exp_q[4].mem_write = 1'b1; exp_q[4].ar_inc = 1'b1;
          exp_q[5].bus_sel = 3'd1; exp_q[5].pc_load = 1'b1;
        end
        default: begin
          len = 7;
          exp_q[4].bus_sel = 3'd7; exp_q[4].mem_read = 1'b1; exp_q[4].dr_load = 1'b1;
          exp_q[5].dr_inc = 1'b1;
          exp_q[6].bus_sel = 3'd3; exp_q[6].mem_write = 1'b1; exp_q[6].pc_inc = dr_zero;
        end
      endcase
    end
  endtask

  // Entered just after a rising edge with sc expected at 0; leaves the same way.
  task automatic run_instr(input string name, input logic [15:0] iv);
    int   len;
    obs_t got, want;
    ir = iv;
    build_expect(iv, len);
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      got  = mask_alu(obs);
      want = mask_alu(exp_q[t]);
      n_checks++;
      if (got !== want || sc !== 4'(t) || running !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ir=%h T%0d: got sc=%0d run=%b strobes=%h, need sc=%0d run=1 strobes=%h",
                 name, iv, t, sc, running, got, t, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string name, input logic exp_run);
    n_checks++;
    if (mask_alu(obs) !== '0 || sc !== 4'd0 || running !== exp_run) begin
      n_fail++;
      $display("FAIL %s: got sc=%0d run=%b strobes=%h, need sc=0 run=%b strobes=0",
               name, sc, running, mask_alu(obs), exp_run);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_hold", 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_cla();
    run_instr("cla", 16'h7800);
  endtask

  task automatic test_add();
    run_instr("add_direct", 16'h1005);
  endtask

  task automatic test_and_indirect();
    run_instr("and_indirect", 16'h8005);
  endtask

  task automatic test_isz();
    dr_zero = 1'b1;
    run_instr("isz_zero", 16'h6010);
    dr_zero = 1'b0;
    run_instr("isz_nonzero", 16'h6010);
  endtask

  task automatic test_e_ops();
    run_instr("cle", 16'h7400);
    run_instr("cme", 16'h7100);
    e_q = 1'b0;
    run_instr("sze", 16'h7002);
    e_q = 1'b1;
    run_instr("sze_set", 16'h7002);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [15:0] iv;
    for (int n = 0; n < 60; n++) begin
      r  = $urandom;
      iv = r[15:0];
      if (iv[14:12] == 3'd7 && !iv[15]) begin
        iv[0] = 1'b0;
        if (iv[9]) begin
          iv[7] = 1'b0; iv[6] = 1'b0;
        end else if (iv[7]) begin
          iv[6] = 1'b0;
        end
      end
      e_q     = r[16];
      ac_msb  = r[17];
      ac_zero = r[18];
      dr_zero = r[19];
      run_instr("random", iv);
    end
  endtask

  task automatic test_hlt();
    run_instr("hlt", 16'h7001);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_idle("halted", 1'b0);
    end
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_idle("reset_mid_cycle", 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_instr("cla_after_restart", 16'h7800);
  endtask

  initial begin
    test_reset();
    test_cla();
    test_add();
    test_and_indirect();
    test_isz();
    test_e_ops();
    test_back_to_back();
    test_hlt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/basic_control_unit.md
# basic_control_unit

Hardwired timing-and-control unit of the Basic Computer. It holds the sequence counter (SC), the decoded opcode flags (D0–D7), the indirect flag (I) and the run flag (S). It drives every register's load/inc/clear strobe, the common-bus select, memory read/write and the ALU operation. It sits directly upstream of the register file, including the E (carry) flip-flop, whose clear/load/increment inputs it drives.

## Interface
Parameters:
- none; encodings and widths come from the shared package.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- ir  in  16  instruction register contents
- e_q  in  1  current E flip-flop value
- ac_msb  in  1  AC[15]
- ac_zero  in  1  AC == 0
- dr_zero  in  1  DR == 0
- ar_load, ar_inc, ar_clr  out  1 each  AR strobes
- pc_load, pc_inc, pc_clr  out  1 each  PC strobes
- dr_load, dr_inc  out  1 each  DR strobes
- ac_load, ac_inc, ac_clr  out  1 each  AC strobes
- ir_load  out  1  IR strobe
- e_clr, e_load, e_inc  out  1 each  E strobes; e_inc complements the 1-bit E
- mem_read, mem_write  out  1 each  memory strobes
- bus_sel  out  3  bus source: 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM, 0 none
- alu_op  out  3  ALU function into AC/E: AND, ADD, PASS_DR, CMA, SHR, SHL
- sc  out  4  sequence counter
- running  out  1  S flag

## Operation
- Registered state: sc[3:0], d[7:0] (one-hot), i_flag, s_flag. All other outputs are combinational decodes of the state and the inputs.
- Target registers act on the strobes at the next clock edge.
- Reset: sc=0, d=0, i_flag=0, s_flag=1. All strobes are forced to 0 while reset_n=0.
- When s_flag=0: every strobe is 0, bus_sel=0, and sc holds its value.
- When s_flag=1: sc increments each cycle unless a step below says "SC←0".
- Fetch:
  - T0: bus_sel=PC, ar_load.
  - T1: bus_sel=MEM, mem_read, ir_load, pc_inc.
  - T2: d←decode(ir[14:12]), i_flag←ir[15], bus_sel=IR, ar_load (ar takes ir[11:0]).
- T3 with D7=0:
  - i_flag=1: bus_sel=MEM, mem_read, ar_load.
  - i_flag=0: no strobes.
- T3 with D7=1 and i_flag=0 (register reference, decoded on ir[11:0]; always SC←0):
  - CLA: ac_clr.
  - CLE: e_clr.
  - CMA: alu_op=CMA, ac_load.
  - CME: e_inc.
  - CIR: alu_op=SHR, ac_load, e_load.
  - CIL: alu_op=SHL, ac_load, e_load.
  - INC: ac_inc.
  - SPA: pc_inc if !ac_msb.
  - SNA: pc_inc if ac_msb.
  - SZA: pc_inc if ac_zero.
  - SZE: pc_inc if !e_q.
  - HLT: s_flag←0.
  - Multiple bits set: all selected actions occur in the same cycle.
  - No bit set: NOP.
- T3 with D7=1 and i_flag=1 (I/O): NOP, SC←0.
- Memory reference:
  - AND (D0): T4 mem_read, bus_sel=MEM, dr_load. T5 alu_op=AND, ac_load, SC←0.
  - ADD (D1): T4 same read as AND. T5 alu_op=ADD, ac_load, e_load, SC←0.
  - LDA (D2): T4 same read as AND. T5 alu_op=PASS_DR, ac_load, SC←0.
  - STA (D3): T4 bus_sel=AC, mem_write, SC←0.
  - BUN (D4): T4 bus_sel=AR, pc_load, SC←0.
  - BSA (D5): T4 bus_sel=PC, mem_write, ar_inc. T5 bus_sel=AR, pc_load, SC←0.
  - ISZ (D6): T4 DR read. T5 dr_inc. T6 bus_sel=DR, mem_write, pc_inc if dr_zero, SC←0.
- sc reaching 15 without an SC←0 is illegal. The design must force SC←0 there, and an assertion must flag it.

## Timing
- Each instruction takes a fixed number of cycles from T0:
  - register reference / I/O: 4
  - STA, BUN: 5
  - AND, ADD, LDA, BSA: 6
  - ISZ: 7
  - indirect addressing adds nothing (T3 is always spent).
- Strobes are valid within the same cycle as the state. There is no added latency.
- In ISZ, dr_zero is sampled at T6, after the T5 increment has taken effect.
- HLT: s_flag clears at the end of T3, and sc is also 0 at that edge. Only reset restarts execution.
- Asynchronous reset mid-instruction aborts immediately. Execution resumes at T0 fetch after deassertion.

## Structure
- Package basic_computer_pkg holds:
  - bus_sel and alu_op localparams
  - register-reference bit positions (CLA=11 … HLT=0)
  - opcode widths and the SC width.
- One natural sub-module: sequence_counter. It is a 4-bit counter with an enable (s_flag), a synchronous clear (SC←0) and the async active-low reset.
- The decode and strobe logic lives in the top module.

## Test plan
- Reset, then IR=0x7800 (CLA): T0–T3 strobes in order, ac_clr at sc=3, sc returns to 0. Total 4 cycles.
- IR=0x1005 (ADD, direct): mem_read+dr_load at T4, then ac_load+e_load with alu_op=ADD at T5. Total 6 cycles.
- IR=0x8005 (AND, indirect): extra mem_read+ar_load at T3, and the rest matches the direct case.
- IR=0x6010 (ISZ) with dr_zero=1 at T6: mem_write and pc_inc at T6. Repeat with dr_zero=0: pc_inc stays 0.
- IR=0x7400 (CLE) → e_clr. Then IR=0x7100 (CME) → e_inc. Then IR=0x7002 (SZE) with e_q=0 → pc_inc.
- IR=0x7001 (HLT): running=0 after T3, and all strobes stay 0 for 20 cycles. Then reset_n pulsed low mid-cycle: running=1 and sc=0 at once.
